sprite_palette_unit: RTL and testbench

- Multi-palette colour lookup for sprite pixels. Each palette is runtime-writable.
- Output is registered over two pipeline stages, with index-0 transparency and a frame-driven fade-to-black sequencer for explosion and death effects.
- Sits between the sprite pixel fetch (index source) and the VGA colour mux.

---
 rtl/sprite_palette_unit.sv | 105 ++++++++++
 tb/tb_sprite_palette_unit.sv | 138 +++++++++++++
 2 files changed

// File: rtl/sprite_palette_unit.sv
// sprite_palette_unit: multi-palette colour lookup with transparency and a frame-driven fade to black
module sprite_palette_unit #(
  parameter int IDX_W   = 4,
  parameter int NUM_PAL = 4,
  parameter int CH_W    = 4
) (
  input  logic                       Clk,
  input  logic                       Reset_n,
  input  logic                       pix_valid,
  input  logic [$clog2(NUM_PAL)-1:0] pal_sel,
  input  logic [IDX_W-1:0]           index,
  input  logic                       wr_en,
  input  logic [$clog2(NUM_PAL)-1:0] wr_pal,
  input  logic [IDX_W-1:0]           wr_idx,
  input  logic [3*CH_W-1:0]          wr_rgb,
  input  logic                       frame_tick,
  input  logic                       fade_start,
  input  logic                       fade_clear,
  output logic [CH_W-1:0]            red,
  output logic [CH_W-1:0]            green,
  output logic [CH_W-1:0]            blue,
  output logic                       transparent,
  output logic                       out_valid,
  output logic                       fade_busy,
  output logic                       fade_done
);
  localparam int E = 3*CH_W;
  localparam int N = 1 << IDX_W;
  localparam logic [CH_W-1:0] LMAX = '1;
  typedef enum logic [1:0] {IDLE, FADING, DONE} state_t;
  logic [E-1:0]    mem_q [NUM_PAL][N];
  logic [E-1:0]    mem_d [NUM_PAL][N];
  logic [E-1:0]    s1_rgb_q, s1_rgb_d, rgb_q, rgb_d;
  logic            s1_tr_q, s1_tr_d, s1_v_q, s1_v_d;
  logic            tr_q, tr_d, ov_q, ov_d;
  logic            busy_q, busy_d, done_q, done_d;
  logic            rd_ok;
  logic [CH_W-1:0] level_q, level_d;
  state_t          state_q, state_d;
  function automatic logic [CH_W-1:0] sub(input logic [CH_W-1:0] c, input logic [CH_W-1:0] l);
    return (c > l) ? c - l : '0;
  endfunction
  always_comb begin
    mem_d = mem_q;
    if (wr_en && int'(wr_pal) < NUM_PAL) mem_d[wr_pal][wr_idx] = wr_rgb;
    // Reads see mem_q, so a same-cycle write to the same entry returns the old value
    rd_ok    = int'(pal_sel) < NUM_PAL;
    s1_rgb_d = rd_ok ? mem_q[pal_sel][index] : '0;
    s1_tr_d  = rd_ok && (index == '0);
    s1_v_d   = pix_valid;
    rgb_d    = s1_v_q ? {sub(s1_rgb_q[E-1 -: CH_W], level_q),
                         sub(s1_rgb_q[2*CH_W-1 -: CH_W], level_q),
                         sub(s1_rgb_q[CH_W-1:0], level_q)} : rgb_q;
    tr_d     = s1_v_q ? s1_tr_q : tr_q;
    ov_d     = s1_v_q;
    state_d  = state_q;
    level_d  = level_q;
    if (fade_clear) begin
      state_d = IDLE;
      level_d = '0;
    end else if (fade_start) begin
      state_d = FADING;
      level_d = '0;
    end else if (state_q == FADING && frame_tick) begin
      level_d = level_q + 1'b1;
      state_d = (level_d == LMAX) ? DONE : FADING;
    end
    busy_d = state_d == FADING;
    done_d = state_d == DONE;
  end
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      mem_q    <= '{default: '0};
      s1_rgb_q <= '0;
      s1_tr_q  <= 1'b0;
      s1_v_q   <= 1'b0;
      rgb_q    <= '0;
      tr_q     <= 1'b0;
      ov_q     <= 1'b0;
      state_q  <= IDLE;
      level_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      s1_rgb_q <= s1_rgb_d;
      s1_tr_q  <= s1_tr_d;
      s1_v_q   <= s1_v_d;
      rgb_q    <= rgb_d;
      tr_q     <= tr_d;
      ov_q     <= ov_d;
      state_q  <= state_d;
      level_q  <= level_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end
  assign red         = rgb_q[E-1 -: CH_W];
  assign green       = rgb_q[2*CH_W-1 -: CH_W];
  assign blue        = rgb_q[CH_W-1:0];
  assign transparent = tr_q;
  assign out_valid   = ov_q;
  assign fade_busy   = busy_q;
  assign fade_done   = done_q;
endmodule

// File: tb/tb_sprite_palette_unit.sv
// tb_sprite_palette_unit: directed checks of palette lookup, transparency, fade and reset
module tb_sprite_palette_unit;
  logic        Clk = 1'b0, Reset_n = 1'b0;
  logic        pix_valid = 0, wr_en = 0, frame_tick = 0, fade_start = 0, fade_clear = 0;
  logic [1:0]  pal_sel = 0, wr_pal = 0;
  logic [3:0]  index = 0, wr_idx = 0;
  logic [11:0] wr_rgb = 0;
  logic [3:0]  red, green, blue;
  logic        transparent, out_valid, fade_busy, fade_done;
  int total = 0, bad = 0;
  sprite_palette_unit dut (
    .Clk(Clk), .Reset_n(Reset_n), .pix_valid(pix_valid), .pal_sel(pal_sel), .index(index),
    .wr_en(wr_en), .wr_pal(wr_pal), .wr_idx(wr_idx), .wr_rgb(wr_rgb),
    .frame_tick(frame_tick), .fade_start(fade_start), .fade_clear(fade_clear),
    .red(red), .green(green), .blue(blue), .transparent(transparent),
    .out_valid(out_valid), .fade_busy(fade_busy), .fade_done(fade_done)
  );
  always #5 Clk = ~Clk;
  task automatic step();
    @(posedge Clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic wr(input logic [1:0] p, input logic [3:0] i, input logic [11:0] d);
    wr_en = 1; wr_pal = p; wr_idx = i; wr_rgb = d;
    step();
    wr_en = 0;
  endtask
  task automatic rd(input logic [1:0] p, input logic [3:0] i);
    pix_valid = 1; pal_sel = p; index = i;
    step();
    pix_valid = 0;
    step();
  endtask
  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      frame_tick = 1;
      step();
      frame_tick = 0;
    end
  endtask
  initial begin
    #1;
    check("reset_rgb", {red, green, blue}, 12'h000);
    check("reset_flags", {out_valid, transparent, fade_busy, fade_done}, 4'b0000);
    #3 Reset_n = 1;
    step();
    wr(1, 5, 12'hD6A);
    rd(1, 5);
    check("basic_rgb", {red, green, blue}, 12'hD6A);
    check("basic_flags", {out_valid, transparent}, 2'b10);
    step();
    check("idle_ov", out_valid, 1'b0);
    check("hold_rgb", {red, green, blue}, 12'hD6A);
    wr(0, 0, 12'h123);
    rd(0, 0);
    check("idx0_rgb", {red, green, blue}, 12'h123);
    check("idx0_flags", {out_valid, transparent}, 2'b11);
    rd(3, 0);
    check("pal3_rgb", {red, green, blue}, 12'h000);
    check("pal3_tr", transparent, 1'b1);
    wr(2, 7, 12'h111);
    wr_en = 1; wr_pal = 2; wr_idx = 7; wr_rgb = 12'hFFF;
    pix_valid = 1; pal_sel = 2; index = 7;
    step();
    wr_en = 0;
    step();
    pix_valid = 0;
    check("rbw_old", {red, green, blue}, 12'h111);
    step();
    check("rbw_new", {red, green, blue}, 12'hFFF);
    check("rbw_ov", out_valid, 1'b1);
    fade_start = 1;
    step();
    fade_start = 0;
    check("fade_busy0", {fade_busy, fade_done}, 2'b10);
    tick(6);
    rd(1, 5);
    check("fade6_rgb", {red, green, blue}, 12'h704);
    check("fade6_st", {fade_busy, fade_done}, 2'b10);
    tick(8);
    check("fade14_st", {fade_busy, fade_done}, 2'b10);
    tick(1);
    check("fade15_st", {fade_busy, fade_done}, 2'b01);
    rd(1, 5);
    check("fade15_rgb", {red, green, blue}, 12'h000);
    tick(1);
    rd(1, 5);
    check("done_hold_rgb", {red, green, blue}, 12'h000);
    check("done_hold_st", {fade_busy, fade_done}, 2'b01);
    fade_start = 1; frame_tick = 1;
    step();
    fade_start = 0; frame_tick = 0;
    rd(1, 5);
    check("start_tick_rgb", {red, green, blue}, 12'hD6A);
    check("start_tick_st", {fade_busy, fade_done}, 2'b10);
    tick(1);
    rd(1, 5);
    check("fade1_rgb", {red, green, blue}, 12'hC59);
    fade_start = 1; fade_clear = 1;
    step();
    fade_start = 0; fade_clear = 0;
    check("clear_st", {fade_busy, fade_done}, 2'b00);
    rd(1, 5);
    check("clear_rgb", {red, green, blue}, 12'hD6A);
    fade_start = 1;
    step();
    fade_start = 0;
    tick(2);
    pix_valid = 1; pal_sel = 1; index = 5;
    step();
    step();
    check("pre_rst_rgb", {red, green, blue}, 12'hB48);
    check("pre_rst_ov", out_valid, 1'b1);
    #2 Reset_n = 0;
    #1;
    check("rst_rgb", {red, green, blue}, 12'h000);
    check("rst_flags", {out_valid, transparent, fade_busy, fade_done}, 4'b0000);
    step();
    Reset_n = 1;
    step();
    check("refill1_ov", out_valid, 1'b0);
    step();
    check("refill2_ov", out_valid, 1'b1);
    check("post_rst_rgb", {red, green, blue}, 12'h000);
    check("post_rst_st", {fade_busy, fade_done}, 2'b00);
    pix_valid = 0;
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
